// File: rtl/bgpu_pkg.sv
// Shared integer-unit types for the compute unit: instruction subtypes and the
// result record exchanged between integer units and the result collector.
package bgpu_pkg;

    typedef enum logic [3:0] {
        IU_ADD,
        IU_SUB,
        IU_AND,
        IU_OR,
        IU_XOR,
        IU_SHL,
        IU_SHR,
        IU_SRA,
        IU_SLT,
        IU_SLTU,
        IU_MIN,
        IU_MAX
    } iu_subtype_e;

    // Field widths of the default compute-unit configuration
    localparam int unsigned IuNumTags     = 8;
    localparam int unsigned IuNumWarps    = 8;
    localparam int unsigned IuRegWidth    = 32;
    localparam int unsigned IuWarpWidth   = 4;
    localparam int unsigned IuRegIdxWidth = 8;
    localparam int unsigned IuIidWidth    = $clog2(IuNumTags) + $clog2(IuNumWarps);

    typedef struct packed {
        logic [IuIidWidth-1:0]              tag;
        logic [IuRegIdxWidth-1:0]           dst;
        logic [IuRegWidth*IuWarpWidth-1:0]  data;
        logic [IuWarpWidth-1:0]             act_mask;
    } iu_result_t;

endpackage

// File: rtl/rr_first_sel.sv
// Round-robin finder: returns the first set request bit at or after the pointer,
// wrapping modulo N.
module rr_first_sel #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         valid_o,
    output logic [W-1:0] sel_o
);

    int unsigned idx;

    // Scan from the farthest offset back to the pointer so the nearest hit wins.
    always_comb begin
        valid_o = 1'b0;
        sel_o   = '0;
        idx     = 0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            idx = 32'(ptr_i) + i[31:0];
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req_i[idx]) begin
                valid_o = 1'b1;
                sel_o   = W'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_register.sv
// One-entry valid/ready pipeline register with full throughput: it accepts a
// new beat whenever it is empty or draining in the same cycle.
module stream_register #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    logic valid_reg;
    T     data_reg;

    assign ready_o = !valid_reg || ready_i;
    assign valid_o = valid_reg;
    assign data_o  = data_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (ready_o) begin
            valid_reg <= valid_i;
            if (valid_i) begin
                data_reg <= data_i;
            end
        end
    end

endmodule

// File: rtl/iu_dispatch_arbiter.sv
// Shares NumUnits integer units between one issue port and one writeback port:
// round-robin dispatch, round-robin result arbitration, per-unit in-flight tracking.
module iu_dispatch_arbiter
    import bgpu_pkg::*;
#(
    parameter int unsigned NumUnits           = 2,
    parameter int unsigned MaxInflightPerUnit = 2,
    parameter int unsigned NumTags            = 8,
    parameter int unsigned NumWarps           = 8,
    parameter int unsigned RegWidth           = 32,
    parameter int unsigned WarpWidth          = 4,
    parameter int unsigned OperandsPerInst    = 2,
    parameter int unsigned RegIdxWidth        = 8,
    localparam int unsigned TagWidth  = $clog2(NumTags),
    localparam int unsigned WidWidth  = (NumWarps > 1) ? $clog2(NumWarps) : 1,
    localparam int unsigned UidWidth  = (NumUnits > 1) ? $clog2(NumUnits) : 1,
    localparam int unsigned CntWidth  = $clog2(MaxInflightPerUnit + 1),
    localparam int unsigned IidWidth  = TagWidth + WidWidth,
    localparam int unsigned DataWidth = RegWidth * WarpWidth
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    output logic                                          eu_to_opc_ready_o,
    input  logic                                          opc_to_eu_valid_i,
    input  logic [IidWidth-1:0]                           opc_to_eu_tag_i,
    input  logic [WarpWidth-1:0]                          opc_to_eu_act_mask_i,
    input  iu_subtype_e                                   opc_to_eu_inst_sub_i,
    input  logic [RegIdxWidth-1:0]                        opc_to_eu_dst_i,
    input  logic [OperandsPerInst-1:0][DataWidth-1:0]     opc_to_eu_operands_i,
    output logic [NumUnits-1:0]                           disp_valid_o,
    input  logic [NumUnits-1:0]                           disp_ready_i,
    output logic [IidWidth-1:0]                           disp_tag_o,
    output logic [WarpWidth-1:0]                          disp_act_mask_o,
    output iu_subtype_e                                   disp_inst_sub_o,
    output logic [RegIdxWidth-1:0]                        disp_dst_o,
    output logic [OperandsPerInst-1:0][DataWidth-1:0]     disp_operands_o,
    input  logic [NumUnits-1:0]                           unit_valid_i,
    output logic [NumUnits-1:0]                           unit_ready_o,
    input  logic [NumUnits-1:0][IidWidth-1:0]             unit_tag_i,
    input  logic [NumUnits-1:0][WarpWidth-1:0]            unit_act_mask_i,
    input  logic [NumUnits-1:0][RegIdxWidth-1:0]          unit_dst_i,
    input  logic [NumUnits-1:0][DataWidth-1:0]            unit_data_i,
    input  logic                                          rc_to_eu_ready_i,
    output logic                                          eu_to_rc_valid_o,
    output logic [IidWidth-1:0]                           eu_to_rc_tag_o,
    output logic [WarpWidth-1:0]                          eu_to_rc_act_mask_o,
    output logic [RegIdxWidth-1:0]                        eu_to_rc_dst_o,
    output logic [DataWidth-1:0]                          eu_to_rc_data_o,
    output logic                                          idle_o
);

    // Same field layout as iu_result_t, sized by this instance's parameters
    typedef struct packed {
        logic [IidWidth-1:0]    tag;
        logic [RegIdxWidth-1:0] dst;
        logic [DataWidth-1:0]   data;
        logic [WarpWidth-1:0]   act_mask;
    } result_t;

    function automatic logic [UidWidth-1:0] wrap_inc(input logic [UidWidth-1:0] p);
        if (32'(p) >= NumUnits - 1) begin
            return '0;
        end
        return p + UidWidth'(1);
    endfunction

    logic [UidWidth-1:0] disp_ptr_reg, disp_ptr_next, disp_sel;
    logic [UidWidth-1:0] res_ptr_reg, res_ptr_next, res_sel;
    logic [NumUnits-1:0] disp_eligible;
    logic [NumUnits-1:0] unit_empty;
    logic                disp_any, disp_fire;
    logic                res_any, res_fire, wb_ready;
    result_t             wb_in, wb_out;

    rr_first_sel #(
        .N (NumUnits),
        .W (UidWidth)
    ) u_disp_sel (
        .req_i   (disp_eligible),
        .ptr_i   (disp_ptr_reg),
        .valid_o (disp_any),
        .sel_o   (disp_sel)
    );

    rr_first_sel #(
        .N (NumUnits),
        .W (UidWidth)
    ) u_res_sel (
        .req_i   (unit_valid_i),
        .ptr_i   (res_ptr_reg),
        .valid_o (res_any),
        .sel_o   (res_sel)
    );

    assign eu_to_opc_ready_o = disp_any;
    assign disp_fire         = opc_to_eu_valid_i && disp_any;
    assign res_fire          = wb_ready && res_any;

    assign disp_tag_o      = opc_to_eu_tag_i;
    assign disp_act_mask_o = opc_to_eu_act_mask_i;
    assign disp_inst_sub_o = opc_to_eu_inst_sub_i;
    assign disp_dst_o      = opc_to_eu_dst_i;
    assign disp_operands_o = opc_to_eu_operands_i;

    for (genvar gi = 0; gi < NumUnits; gi++) begin : g_unit
        logic [CntWidth-1:0] cnt_reg, cnt_next;
        logic                issue_hs, result_hs;

        assign disp_eligible[gi] = disp_ready_i[gi] && (cnt_reg < CntWidth'(MaxInflightPerUnit));
        assign disp_valid_o[gi]  = disp_fire && (disp_sel == UidWidth'(gi));
        assign unit_ready_o[gi]  = res_fire && (res_sel == UidWidth'(gi));
        assign issue_hs          = disp_valid_o[gi] && disp_ready_i[gi];
        assign result_hs         = unit_ready_o[gi] && unit_valid_i[gi];
        assign unit_empty[gi]    = (cnt_reg == '0);

        always_comb begin
            cnt_next = cnt_reg;
            if (issue_hs && !result_hs) begin
                cnt_next = cnt_reg + CntWidth'(1);
            end else if (!issue_hs && result_hs) begin
                cnt_next = cnt_reg - CntWidth'(1);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_next;
            end
        end

`ifndef SYNTHESIS
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(result_hs && !issue_hs && cnt_reg == '0))
            else $error("unit %0d: result returned with nothing in flight", gi);
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(issue_hs && !result_hs && cnt_reg == CntWidth'(MaxInflightPerUnit)))
            else $error("unit %0d: issue beyond in-flight limit", gi);
`endif
    end

    always_comb begin
        wb_in          = '0;
        wb_in.tag      = unit_tag_i[res_sel];
        wb_in.dst      = unit_dst_i[res_sel];
        wb_in.data     = unit_data_i[res_sel];
        wb_in.act_mask = unit_act_mask_i[res_sel];
    end

    stream_register #(
        .T (result_t)
    ) u_wb_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (res_any),
        .ready_o (wb_ready),
        .data_i  (wb_in),
        .valid_o (eu_to_rc_valid_o),
        .ready_i (rc_to_eu_ready_i),
        .data_o  (wb_out)
    );

    assign eu_to_rc_tag_o      = wb_out.tag;
    assign eu_to_rc_dst_o      = wb_out.dst;
    assign eu_to_rc_data_o     = wb_out.data;
    assign eu_to_rc_act_mask_o = wb_out.act_mask;

    assign idle_o = (&unit_empty) && !eu_to_rc_valid_o;

    always_comb begin
        disp_ptr_next = disp_fire ? wrap_inc(disp_sel) : disp_ptr_reg;
        res_ptr_next  = res_fire ? wrap_inc(res_sel) : res_ptr_reg;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            disp_ptr_reg <= '0;
            res_ptr_reg  <= '0;
        end else begin
            disp_ptr_reg <= disp_ptr_next;
            res_ptr_reg  <= res_ptr_next;
        end
    end

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (eu_to_rc_valid_o && !rc_to_eu_ready_i) |=> (eu_to_rc_valid_o && $stable(wb_out)))
        else $error("writeback payload changed while stalled");
`endif

endmodule

// File: tb/tb_iu_dispatch_arbiter.sv
// Directed scoreboard bench for iu_dispatch_arbiter in its default configuration.
module tb_iu_dispatch_arbiter;
    import bgpu_pkg::*;

    localparam int NU = 2;

    typedef struct {
        logic [NU-1:0] onehot;
        logic [5:0]    tag;
    } disp_exp_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                 eu_to_opc_ready_o;
    logic                 opc_to_eu_valid_i;
    logic [5:0]           opc_to_eu_tag_i;
    logic [3:0]           opc_to_eu_act_mask_i;
    iu_subtype_e          opc_to_eu_inst_sub_i;
    logic [7:0]           opc_to_eu_dst_i;
    logic [1:0][127:0]    opc_to_eu_operands_i;
    logic [NU-1:0]        disp_valid_o;
    logic [NU-1:0]        disp_ready_i;
    logic [5:0]           disp_tag_o;
    logic [3:0]           disp_act_mask_o;
    iu_subtype_e          disp_inst_sub_o;
    logic [7:0]           disp_dst_o;
    logic [1:0][127:0]    disp_operands_o;
    logic [NU-1:0]        unit_valid_i;
    logic [NU-1:0]        unit_ready_o;
    logic [NU-1:0][5:0]   unit_tag_i;
    logic [NU-1:0][3:0]   unit_act_mask_i;
    logic [NU-1:0][7:0]   unit_dst_i;
    logic [NU-1:0][127:0] unit_data_i;
    logic                 rc_to_eu_ready_i;
    logic                 eu_to_rc_valid_o;
    logic [5:0]           eu_to_rc_tag_o;
    logic [3:0]           eu_to_rc_act_mask_o;
    logic [7:0]           eu_to_rc_dst_o;
    logic [127:0]         eu_to_rc_data_o;
    logic                 idle_o;

    iu_dispatch_arbiter dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .eu_to_opc_ready_o    (eu_to_opc_ready_o),
        .opc_to_eu_valid_i    (opc_to_eu_valid_i),
        .opc_to_eu_tag_i      (opc_to_eu_tag_i),
        .opc_to_eu_act_mask_i (opc_to_eu_act_mask_i),
        .opc_to_eu_inst_sub_i (opc_to_eu_inst_sub_i),
        .opc_to_eu_dst_i      (opc_to_eu_dst_i),
        .opc_to_eu_operands_i (opc_to_eu_operands_i),
        .disp_valid_o         (disp_valid_o),
        .disp_ready_i         (disp_ready_i),
        .disp_tag_o           (disp_tag_o),
        .disp_act_mask_o      (disp_act_mask_o),
        .disp_inst_sub_o      (disp_inst_sub_o),
        .disp_dst_o           (disp_dst_o),
        .disp_operands_o      (disp_operands_o),
        .unit_valid_i         (unit_valid_i),
        .unit_ready_o         (unit_ready_o),
        .unit_tag_i           (unit_tag_i),
        .unit_act_mask_i      (unit_act_mask_i),
        .unit_dst_i           (unit_dst_i),
        .unit_data_i          (unit_data_i),
        .rc_to_eu_ready_i     (rc_to_eu_ready_i),
        .eu_to_rc_valid_o     (eu_to_rc_valid_o),
        .eu_to_rc_tag_o       (eu_to_rc_tag_o),
        .eu_to_rc_act_mask_o  (eu_to_rc_act_mask_o),
        .eu_to_rc_dst_o       (eu_to_rc_dst_o),
        .eu_to_rc_data_o      (eu_to_rc_data_o),
        .idle_o               (idle_o)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    disp_exp_t   disp_q[$];
    iu_result_t  wb_q[$];
    iu_result_t  uq0[$];
    iu_result_t  uq1[$];
    logic [NU-1:0] unit_en = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic iu_result_t make_res(input logic [5:0] t);
        iu_result_t r;
        r.tag      = t;
        r.dst      = {2'b00, t} + 8'd32;
        r.data     = {4{{26'h15A5A5A, t}}};
        r.act_mask = t[3:0] ^ 4'h5;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one instruction; the expected one-hot steering is hand-derived by the caller.
    task automatic issue(input logic [5:0] tag, input logic [NU-1:0] ready, input logic [NU-1:0] exp_onehot);
        disp_exp_t e;
        e.onehot = exp_onehot;
        e.tag    = tag;
        disp_q.push_back(e);
        opc_to_eu_valid_i    = 1'b1;
        opc_to_eu_tag_i      = tag;
        opc_to_eu_dst_i      = {2'b00, tag};
        opc_to_eu_operands_i = {2{{122'h0, tag}}};
        disp_ready_i         = ready;
        tick();
        opc_to_eu_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (wb_q.size() > 0 && k < 50) begin
            @(negedge clk_i);
            k++;
        end
        check("wb_drain_pending", 128'(wb_q.size()), 128'(0));
    endtask

    // Integer-unit model: presents queued results, pops one on each result handshake.
    initial begin : unit_model
        logic [NU-1:0] hs;
        unit_valid_i    = '0;
        unit_tag_i      = '0;
        unit_act_mask_i = '0;
        unit_dst_i      = '0;
        unit_data_i     = '0;
        forever begin
            @(negedge clk_i);
            hs = unit_valid_i & unit_ready_o;
            @(posedge clk_i);
            #2;
            if (hs[0] && uq0.size() > 0) void'(uq0.pop_front());
            if (hs[1] && uq1.size() > 0) void'(uq1.pop_front());
            unit_valid_i[0] = unit_en[0] && (uq0.size() > 0);
            unit_valid_i[1] = unit_en[1] && (uq1.size() > 0);
            if (uq0.size() > 0) begin
                unit_tag_i[0]      = uq0[0].tag;
                unit_dst_i[0]      = uq0[0].dst;
                unit_data_i[0]     = uq0[0].data;
                unit_act_mask_i[0] = uq0[0].act_mask;
            end
            if (uq1.size() > 0) begin
                unit_tag_i[1]      = uq1[0].tag;
                unit_dst_i[1]      = uq1[0].dst;
                unit_data_i[1]     = uq1[0].data;
                unit_act_mask_i[1] = uq1[0].act_mask;
            end
        end
    end

    // Monitor: compares every issue and writeback handshake against the scoreboard.
    initial begin : monitor
        disp_exp_t  de;
        iu_result_t we;
        forever begin
            @(negedge clk_i);
            if (rst_ni && opc_to_eu_valid_i && eu_to_opc_ready_o) begin
                if (disp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL disp_unexpected: got issue to %b expected none", disp_valid_o);
                end else begin
                    de = disp_q.pop_front();
                    check("disp_valid", 128'(disp_valid_o), 128'(de.onehot));
                    check("disp_tag", 128'(disp_tag_o), 128'(de.tag));
                    $display("issue tag=%0d -> units %b", disp_tag_o, disp_valid_o);
                end
            end
            if (rst_ni && eu_to_rc_valid_o && rc_to_eu_ready_i) begin
                if (wb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wb_unexpected: got tag %0d expected none", eu_to_rc_tag_o);
                end else begin
                    we = wb_q.pop_front();
                    check("wb_tag", 128'(eu_to_rc_tag_o), 128'(we.tag));
                    check("wb_dst", 128'(eu_to_rc_dst_o), 128'(we.dst));
                    check("wb_data", eu_to_rc_data_o, we.data);
                    check("wb_mask", 128'(eu_to_rc_act_mask_o), 128'(we.act_mask));
                    $display("writeback tag=%0d dst=%0d", eu_to_rc_tag_o, eu_to_rc_dst_o);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        iu_result_t r0;
        opc_to_eu_valid_i    = 1'b0;
        opc_to_eu_tag_i      = '0;
        opc_to_eu_act_mask_i = 4'hF;
        opc_to_eu_inst_sub_i = IU_ADD;
        opc_to_eu_dst_i      = '0;
        opc_to_eu_operands_i = '0;
        disp_ready_i         = '0;
        rc_to_eu_ready_i     = 1'b1;

        // Reset state
        repeat (2) @(negedge clk_i);
        check("rst_idle", 128'(idle_o), 128'(1));
        check("rst_wb_valid", 128'(eu_to_rc_valid_o), 128'(0));
        check("rst_unit_ready", 128'(unit_ready_o), 128'(0));
        check("rst_wb_tag", 128'(eu_to_rc_tag_o), 128'(0));
        check("rst_wb_data", eu_to_rc_data_o, 128'(0));
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        tick();

        // Four back-to-back issues alternate units, then both units sit at the limit
        issue(6'd0, 2'b11, 2'b01);
        issue(6'd1, 2'b11, 2'b10);
        issue(6'd2, 2'b11, 2'b01);
        issue(6'd3, 2'b11, 2'b10);
        opc_to_eu_valid_i = 1'b1;
        opc_to_eu_tag_i   = 6'd7;
        disp_ready_i      = 2'b11;
        @(negedge clk_i);
        check("full_opc_ready", 128'(eu_to_opc_ready_o), 128'(0));
        check("full_disp_valid", 128'(disp_valid_o), 128'(0));
        check("busy_idle", 128'(idle_o), 128'(0));
        tick();
        opc_to_eu_valid_i = 1'b0;

        // Both units return together; first result stalls for five cycles
        r0 = make_res(6'd0);
        uq0.push_back(r0);
        uq0.push_back(make_res(6'd2));
        uq1.push_back(make_res(6'd1));
        uq1.push_back(make_res(6'd3));
        wb_q.push_back(r0);
        wb_q.push_back(make_res(6'd1));
        wb_q.push_back(make_res(6'd2));
        wb_q.push_back(make_res(6'd3));
        rc_to_eu_ready_i = 1'b0;
        unit_en          = 2'b11;
        @(negedge clk_i);
        check("first_grant", 128'(unit_ready_o), 128'(2'b01));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check("stall_unit_ready", 128'(unit_ready_o), 128'(0));
            check("stall_valid", 128'(eu_to_rc_valid_o), 128'(1));
            check("stall_tag", 128'(eu_to_rc_tag_o), 128'(r0.tag));
            check("stall_data", eu_to_rc_data_o, r0.data);
        end
        @(posedge clk_i);
        #1 rc_to_eu_ready_i = 1'b1;
        @(negedge clk_i);
        check("release_grant", 128'(unit_ready_o), 128'(2'b10));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("throughput_valid", 128'(eu_to_rc_valid_o), 128'(1));
        end
        wait_drain();
        unit_en = 2'b00;
        tick();
        @(negedge clk_i);
        check("drained_idle", 128'(idle_o), 128'(1));
        tick();

        // Unit0 busy: instruction goes to unit1 and the pointer wraps back to 0
        issue(6'd8, 2'b10, 2'b10);
        issue(6'd9, 2'b11, 2'b01);

        // Same-cycle issue and result on unit0 leaves its count at 1
        uq0.push_back(make_res(6'd9));
        wb_q.push_back(make_res(6'd9));
        disp_q.push_back('{onehot: 2'b01, tag: 6'd10});
        unit_en              = 2'b01;
        opc_to_eu_valid_i    = 1'b1;
        opc_to_eu_tag_i      = 6'd10;
        disp_ready_i         = 2'b01;
        @(negedge clk_i);
        check("same_cycle_grant", 128'(unit_ready_o), 128'(2'b01));
        tick();
        opc_to_eu_valid_i = 1'b0;
        unit_en           = 2'b00;
        tick();
        disp_q.push_back('{onehot: 2'b01, tag: 6'd11});
        opc_to_eu_valid_i = 1'b1;
        opc_to_eu_tag_i   = 6'd11;
        @(negedge clk_i);
        check("cnt1_opc_ready", 128'(eu_to_opc_ready_o), 128'(1));
        tick();
        @(negedge clk_i);
        check("cnt2_opc_ready", 128'(eu_to_opc_ready_o), 128'(0));
        tick();
        opc_to_eu_valid_i = 1'b0;

        // Drain everything: result pointer sits at unit1, so unit1 goes first
        uq0.push_back(make_res(6'd10));
        uq0.push_back(make_res(6'd11));
        uq1.push_back(make_res(6'd8));
        wb_q.push_back(make_res(6'd8));
        wb_q.push_back(make_res(6'd10));
        wb_q.push_back(make_res(6'd11));
        unit_en = 2'b11;
        @(negedge clk_i);
        check("drain_first_grant", 128'(unit_ready_o), 128'(2'b10));
        check("inflight_idle", 128'(idle_o), 128'(0));
        wait_drain();
        unit_en = 2'b00;
        tick();
        @(negedge clk_i);
        check("final_idle", 128'(idle_o), 128'(1));
        check("disp_q_empty", 128'(disp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
